// File: rtl/vga_scan_generator.sv
// vga_scan_generator
//   Raster scan generator for the VGA pipeline. Produces the current pixel
//   coordinates together with sync, blanking and start-of-line/frame strobes.
//   The scan advances only on clk edges where pixelEn is high. All outputs
//   are registered and always describe the new (pixelX, pixelY).
//
// Ports:
//   clk            system clock
//   resetN         asynchronous active-low reset
//   pixelEn        pixel tick, scan advances when high
//   pixelX         current horizontal position, 0..H_TOTAL-1
//   pixelY         current line, 0..V_TOTAL-1
//   hSync          horizontal sync, SYNC_ACTIVE while asserted
//   vSync          vertical sync, SYNC_ACTIVE while asserted
//   displayEnable  high inside the visible area
//   startOfFrame   one-clk pulse on the advance into (0,0)
//   startOfLine    one-clk pulse on every advance into pixelX=0

module vga_scan_generator #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               pixelEn,
    output logic signed [10:0] pixelX,
    output logic signed [10:0] pixelY,
    output logic               hSync,
    output logic               vSync,
    output logic               displayEnable,
    output logic               startOfFrame,
    output logic               startOfLine
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Coordinates must stay positive when viewed as 11-bit signed values.
    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_timing
        $error("vga_scan_generator: H_TOTAL and V_TOTAL must not exceed 1023");
    end

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
    localparam logic [10:0] X_HFP     = 11'(H_ACTIVE);
    localparam logic [10:0] X_HSYNC   = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] X_HBP     = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] Y_VFP     = 11'(V_ACTIVE);
    localparam logic [10:0] Y_VSYNC   = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] Y_VBP     = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {HACT, HFP, HSYNC, HBP} hphase_t;
    typedef enum logic [1:0] {VACT, VFP, VSYNC, VBP} vphase_t;

    logic [10:0] xCnt, yCnt;
    logic [10:0] xNext, yNext;
    hphase_t     hState, hNext;
    vphase_t     vState, vNext;
    logic        lineWrap, frameWrap;

    assign pixelX = $signed(xCnt);
    assign pixelY = $signed(yCnt);

    // Next coordinates and phases. Phase changes are keyed off the boundary
    // coordinate being entered; the wrap check comes last so any corrupted
    // phase is forced back to the active decode on the next wrap.
    always_comb begin
        xNext     = xCnt + 11'd1;
        yNext     = yCnt;
        hNext     = hState;
        vNext     = vState;
        lineWrap  = 1'b0;
        frameWrap = 1'b0;

        if (xCnt == H_LAST) begin
            xNext    = '0;
            lineWrap = 1'b1;
            if (yCnt == V_LAST) begin
                yNext     = '0;
                frameWrap = 1'b1;
            end else begin
                yNext = yCnt + 11'd1;
            end
        end

        if (xNext == X_HFP)   hNext = HFP;
        if (xNext == X_HSYNC) hNext = HSYNC;
        if (xNext == X_HBP)   hNext = HBP;
        if (lineWrap)         hNext = HACT;

        if (lineWrap) begin
            if (yNext == Y_VFP)   vNext = VFP;
            if (yNext == Y_VSYNC) vNext = VSYNC;
            if (yNext == Y_VBP)   vNext = VBP;
            if (frameWrap)        vNext = VACT;
        end
    end

    // Strobes are decoded from the next phase so they line up with the new
    // coordinates on the same edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            xCnt          <= H_LAST;
            yCnt          <= V_LAST;
            hState        <= HBP;
            vState        <= VBP;
            hSync         <= ~SYNC_ACTIVE;
            vSync         <= ~SYNC_ACTIVE;
            displayEnable <= 1'b0;
            startOfFrame  <= 1'b0;
            startOfLine   <= 1'b0;
        end else if (pixelEn) begin
            xCnt          <= xNext;
            yCnt          <= yNext;
            hState        <= hNext;
            vState        <= vNext;
            hSync         <= (hNext == HSYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vSync         <= (vNext == VSYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            displayEnable <= (hNext == HACT) && (vNext == VACT);
            startOfFrame  <= frameWrap;
            startOfLine   <= lineWrap;
        end else begin
            startOfFrame  <= 1'b0;
            startOfLine   <= 1'b0;
        end
    end

endmodule

// File: doc/vga_scan_generator.md
Name: vga_scan_generator

Overview:
- Produces the raster scan coordinates (pixelX, pixelY) and VGA sync/blanking strobes that every on-screen object block consumes.
- Object blocks compare these coordinates against their position and return offsets and inside flags.
- Sits at the top of the VGA pipeline, driven by the system clock with a pixel-rate enable.
- Default timing is 640x480@60 with a 25.175 MHz-class pixel tick.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, logic level of hSync/vSync while asserted

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- pixelEn  in  1  pixel tick; the scan advances only on clk edges where pixelEn=1
- pixelX  out  11 signed  current horizontal position, 0..H_TOTAL-1
- pixelY  out  11 signed  current line, 0..V_TOTAL-1
- hSync  out  1  horizontal sync, level SYNC_ACTIVE while asserted
- vSync  out  1  vertical sync, level SYNC_ACTIVE while asserted
- displayEnable  out  1  high when pixelX<H_ACTIVE and pixelY<V_ACTIVE
- startOfFrame  out  1  one-clk pulse on the advance into (0,0)
- startOfLine  out  1  one-clk pulse on every advance into pixelX=0

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (800), V_TOTAL = sum of the V_* parameters (525).
- Elaboration must fail if H_TOTAL>1023 or V_TOTAL>1023, so coordinates stay positive in 11-bit signed.
- Reset (async, resetN=0):
  - pixelX=H_TOTAL-1, pixelY=V_TOTAL-1
  - hSync=vSync=~SYNC_ACTIVE
  - displayEnable=0, startOfFrame=0, startOfLine=0
  - This means the first enabled tick after reset lands on (0,0) and raises startOfFrame.
- All outputs are registers. They update on the same clk edge as the counters and always describe the new (pixelX, pixelY); there is no extra latency between coordinates and strobes.
- pixelEn=1 edge:
  - If pixelX=H_TOTAL-1: pixelX<=0, startOfLine<=1.
    - If pixelY=V_TOTAL-1 also: pixelY<=0, startOfFrame<=1.
    - Otherwise: pixelY<=pixelY+1.
  - Otherwise: pixelX<=pixelX+1.
- pixelEn=0 edge: pixelX, pixelY, hSync, vSync and displayEnable hold; startOfFrame and startOfLine go to 0, so each pulse is exactly 1 clk wide.
- Horizontal phase FSM (HACT, HFP, HSYNC, HBP) is advanced with pixelX:
  - HACT for x<640, HFP for 640..655, HSYNC for 656..751, HBP for 752..799, then wraps to HACT.
  - hSync=SYNC_ACTIVE exactly while in HSYNC.
- Vertical phase FSM (VACT, VFP, VSYNC, VBP) advances only on line wrap:
  - VACT for y<480, VFP for 480..489, VSYNC for 490..491, VBP for 492..524.
  - vSync=SYNC_ACTIVE exactly while in VSYNC; it changes on the same edge that pixelX goes to 0.
- FSM state must always match the counter ranges. Any illegal or unreachable encoding recovers to the HACT/VACT decode on the next line/frame wrap.
- Continuous pixelEn=1 gives a line period of 800 clks and a frame period of 420000 clks.
- Reset asserted mid-frame returns to the reset values immediately; no partial pulses are emitted after release.

Test Plan:
- Release reset with pixelEn=1 -> first edge: (0,0), startOfFrame=1, startOfLine=1, displayEnable=1; next edge: (1,0), both pulses 0.
- Free-run one line -> displayEnable falls as pixelX goes 639->640; hSync=0 for pixelX 656..751 inclusive (96 clks); startOfLine recurs after exactly 800 enabled edges.
- Free-run one frame -> vSync=0 for pixelY 490..491 (1600 enabled edges); startOfFrame period is exactly 420000 enabled edges; pixelY wraps 524->0 on the same edge pixelX wraps 799->0.
- pixelEn toggled 1,0,1,0 (one tick every 2 clks) -> outputs hold on pixelEn=0 edges; the startOfLine pulse at x=0 stays 1 clk wide; the line takes 1600 clks.
- Assert resetN=0 at (700,300) in HSYNC -> hSync immediately goes to 1, pixelX=799, pixelY=524; after release, first tick gives (0,0) with startOfFrame=1.
- SYNC_ACTIVE=1 build -> hSync and vSync are inverted relative to the default; all other outputs are identical cycle-for-cycle.
